pipe_skid_reg: RTL and testbench

//   Parametrised pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_skid_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic inter-stage pipeline register with a valid/ready handshake.
//
// Replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. The stage packs its control
// and data fields into in_ctrl/in_data. Stalls arrive as out_ready=0 and kills as flush.
//
// With SKID_EN=1 a second (skid) entry absorbs the one extra beat that upstream may push
// while downstream stalls. This lets in_ready come straight from a flop, so there is no
// combinational out_ready -> in_ready path, and full throughput is kept. With SKID_EN=0
// only the main entry is used, and in_ready is a function of out_ready.
//
// Parameters:
//   CTRL_W    width of the control bundle; reads as zero on bubbles and is cleared by flush
//   DATA_W    width of the data bundle
//   SKID_EN   1: two entries with a registered in_ready; 0: one entry with a combinational in_ready
//   CLR_DATA  1: flush also zeroes the data storage; 0: only reset clears data
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of held and incoming entries (highest priority)
//   in_valid   upstream entry present
//   in_ready   stage can accept; accept = in_valid & in_ready
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  head entry presented downstream
//   out_ready  downstream accepts; fire = out_valid & out_ready
//   out_ctrl   head control bundle, forced to 0 when out_valid=0
//   out_data   head data bundle
//   occupancy  number of held entries (0..2)

module pipe_skid_reg #(
  parameter int unsigned CTRL_W   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter bit          SKID_EN  = 1'b1,
  parameter bit          CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // StEmpty: nothing held. StOne: main entry only. StFull: main and skid entries.
  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;

  logic m_valid;
  logic s_valid;
  logic accept;
  logic fire;

  assign m_valid = (state_q != StEmpty);
  assign s_valid = (state_q == StFull);

  // Skid build: in_ready is a registered copy of "next state is not full".
  // Single-entry build: the head can be replaced in the same cycle it leaves.
  assign in_ready = SKID_EN ? in_ready_q : (~m_valid | out_ready);

  assign accept = in_valid & in_ready;
  assign fire   = m_valid & out_ready;

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (accept && fire) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end else if (accept && SKID_EN) begin
          // Head is stalled; park the new beat behind it.
          s_ctrl_d = in_ctrl;
          s_data_d = in_data;
          state_d  = StFull;
        end else if (fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the head can move.
        if (fire) begin
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
          state_d  = StOne;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase

    // A fire in this cycle has already been sampled downstream; only held/incoming
    // entries are killed.
    if (flush) begin
      state_d  = StEmpty;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      if (CLR_DATA) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end

    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      m_ctrl_q   <= '0;
      m_data_q   <= '0;
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [3:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  logic        d1_in_ready, d1_out_valid;
  logic [3:0]  d1_out_ctrl;
  logic [31:0] d1_out_data;
  logic [1:0]  d1_occ;

  logic        d0_in_ready, d0_out_valid;
  logic [3:0]  d0_out_ctrl;
  logic [31:0] d0_out_data;
  logic [1:0]  d0_occ;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(
    .CTRL_W  (4),
    .DATA_W  (32),
    .SKID_EN (1'b1),
    .CLR_DATA(1'b1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (d1_in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(d1_out_valid),
    .out_ready(out_ready),
    .out_ctrl (d1_out_ctrl),
    .out_data (d1_out_data),
    .occupancy(d1_occ)
  );

  pipe_skid_reg #(
    .CTRL_W  (4),
    .DATA_W  (32),
    .SKID_EN (1'b0),
    .CLR_DATA(1'b1)
  ) u_single (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (d0_in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(d0_out_valid),
    .out_ready(out_ready),
    .out_ctrl (d0_out_ctrl),
    .out_data (d0_out_data),
    .occupancy(d0_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each build is an ordered queue of held entries.
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] data;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete();
      q0.delete();
    end else begin
      bit f1, a1, f0, a0;
      f1 = (q1.size() > 0) && out_ready;
      a1 = in_valid && (q1.size() < 2);
      f0 = (q0.size() > 0) && out_ready;
      a0 = in_valid && ((q0.size() == 0) || out_ready);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (f1) void'(q1.pop_front());
        if (a1) q1.push_back({in_ctrl, in_data});
        if (f0) void'(q0.pop_front());
        if (a0) q0.push_back({in_ctrl, in_data});
      end
    end
  end

  // Compare both builds against the model every cycle, mid-period.
  always @(negedge clk) begin
    ent_t h;
    chk("skid_out_valid", {31'd0, d1_out_valid}, {31'd0, q1.size() != 0});
    chk("skid_occupancy", {30'd0, d1_occ}, q1.size());
    chk("skid_in_ready", {31'd0, d1_in_ready}, {31'd0, q1.size() < 2});
    if (q1.size() != 0) begin
      h = q1[0];
      chk("skid_out_ctrl", {28'd0, d1_out_ctrl}, {28'd0, h.ctrl});
      chk("skid_out_data", d1_out_data, h.data);
    end else begin
      chk("skid_bubble_ctrl", {28'd0, d1_out_ctrl}, 32'd0);
    end
    chk("single_out_valid", {31'd0, d0_out_valid}, {31'd0, q0.size() != 0});
    chk("single_occupancy", {30'd0, d0_occ}, q0.size());
    chk("single_in_ready", {31'd0, d0_in_ready},
        {31'd0, (q0.size() == 0) || out_ready});
    if (q0.size() != 0) begin
      h = q0[0];
      chk("single_out_ctrl", {28'd0, d0_out_ctrl}, {28'd0, h.ctrl});
      chk("single_out_data", d0_out_data, h.data);
    end else begin
      chk("single_bubble_ctrl", {28'd0, d0_out_ctrl}, 32'd0);
    end
  end

  initial begin
    // Reset with a live-looking input.
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h7;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, d1_out_valid}, 32'd0);
    chk("rst_out_ctrl", {28'd0, d1_out_ctrl}, 32'd0);
    chk("rst_out_data", d1_out_data, 32'd0);
    chk("rst_occupancy", {30'd0, d1_occ}, 32'd0);
    chk("rst_in_ready", {31'd0, d1_in_ready}, 32'd1);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i > 1) chk("stream_data", d1_out_data, i - 1);
      in_valid = 1'b1;
      in_ctrl  = 4'h1;
      in_data  = i;
      #1 chk("stream_in_ready", {31'd0, d1_in_ready}, 32'd1);
    end
    tick();
    chk("stream_data", d1_out_data, 32'd8);
    in_valid = 1'b0;

    // Skid: stall on the cycle 0xB arrives.
    tick();
    in_valid = 1'b1; in_ctrl = 4'h2; in_data = 32'hA;
    tick();
    in_data = 32'hB; out_ready = 1'b0;
    #1 chk("skid_head_a0", d1_out_data, 32'hA);
    tick();
    in_data = 32'hC;
    #1;
    chk("skid_occ_full", {30'd0, d1_occ}, 32'd2);
    chk("skid_in_ready_low", {31'd0, d1_in_ready}, 32'd0);
    chk("skid_head_a1", d1_out_data, 32'hA);
    tick();
    chk("skid_hold_a", d1_out_data, 32'hA);
    chk("skid_hold_occ", {30'd0, d1_occ}, 32'd2);
    out_ready = 1'b1;
    tick();
    chk("skid_drain_b", d1_out_data, 32'hB);
    chk("skid_drain_occ", {30'd0, d1_occ}, 32'd1);
    tick();
    in_valid = 1'b0;
    #1 chk("skid_drain_c", d1_out_data, 32'hC);
    tick();
    chk("skid_empty", {30'd0, d1_occ}, 32'd0);

    // Bubbles must not leak control.
    in_ctrl = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_valid", {31'd0, d1_out_valid}, 32'd0);
      chk("bubble_ctrl", {28'd0, d1_out_ctrl}, 32'd0);
    end

    // Flush while full, with a new beat offered in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'h3; in_data = 32'h11;
    tick();
    in_ctrl = 4'h4; in_data = 32'h22;
    tick();
    in_ctrl = 4'h5; in_data = 32'h55; flush = 1'b1;
    #1 chk("flush_pre_occ", {30'd0, d1_occ}, 32'd2);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_occ", {30'd0, d1_occ}, 32'd0);
    chk("flush_ctrl", {28'd0, d1_out_ctrl}, 32'd0);
    chk("flush_data", d1_out_data, 32'd0);
    chk("flush_in_ready", {31'd0, d1_in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_55", {31'd0, d1_out_valid}, 32'd0);
    end

    // Single-entry build: in_ready follows out_ready combinationally.
    in_valid = 1'b1; in_ctrl = 4'h6; in_data = 32'h66; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_held_data", d0_out_data, 32'h66);
    chk("single_ready_low", {31'd0, d0_in_ready}, 32'd0);
    out_ready = 1'b1;
    #1 chk("single_ready_comb", {31'd0, d0_in_ready}, 32'd1);

    // Random traffic, occasional flush and asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      tick();
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 65);
      flush     = ($urandom_range(99) < 4);
      in_ctrl   = 4'($urandom);
      in_data   = $urandom;
      if ($urandom_range(499) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_occ", {30'd0, d1_occ}, 32'd0);
        chk("async_rst_valid", {31'd0, d1_out_valid}, 32'd0);
        #1 rst_n = 1'b1;
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
